// File: rtl/bnn_pkg.sv
// Shared definitions for the binary neural network pipeline: global
// sequencing states, layer geometry, the per-class output bias table and
// the local state encoding of the final dense layer.
package bnn_pkg;

   // Global pipeline sequencing states driven by the top-level controller.
   typedef enum logic [2:0] {
      s_IDLE         = 3'b000,
      s_LAYER_1      = 3'b001,
      s_LAYER_2      = 3'b010,
      s_LAYER_2_POOL = 3'b011,
      s_LAYER_3      = 3'b100
   } global_state_t;

   // Dense output layer geometry: 4 filter planes of 7x7 features, 10 classes.
   localparam int NUM_CLASSES = 10;
   localparam int FEAT_BITS   = 196;
   localparam int CHUNK_BITS  = 49;
   localparam int NUM_CHUNKS  = FEAT_BITS / CHUNK_BITS;

   // Local control states of the dense output layer.
   typedef enum logic {
      RUN = 1'b0,
      FIN = 1'b1
   } l3_state_t;

   // Per-class signed bias added to the XNOR-popcount score.
   function automatic logic signed [8:0] bias_of(input logic [3:0] cls);
      logic signed [8:0] b;
      case (cls)
         4'd0:    b = -9'sd2;
         4'd1:    b =  9'sd5;
         4'd2:    b =  9'sd0;
         4'd3:    b =  9'sd3;
         4'd4:    b = -9'sd1;
         4'd5:    b =  9'sd0;
         4'd6:    b =  9'sd2;
         4'd7:    b = -9'sd4;
         4'd8:    b =  9'sd1;
         4'd9:    b =  9'sd0;
         default: b =  9'sd0;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/popcount49.sv
// Combinational population count of a 49-bit vector (result 0..49).
module popcount49 (
   input  logic [48:0] bits,
   output logic [5:0]  count
);

   // Sum the set bits; synthesis turns this into an adder tree.
   always_comb begin
      // NOTE: every always_comb output is assigned a default first so that no path leaves it unassigned and infers a latch.
      count = '0;
      for (int i = 0; i < 49; i++) begin
         count = count + 6'(bits[i]);
      end
   end

endmodule

// File: rtl/layer_three.sv
// Dense binary output layer of the classifier. While the global state is
// s_LAYER_3 it scores one 49-bit feature plane against one class per cycle
// (XNOR + popcount), accumulates four planes per class, and keeps the best
// class seen so far. After 40 active cycles the winning digit and its score
// are held with a sticky done flag until reset.
// Build option: define LAYER_THREE_BIAS_EN to add the per-class bias from
// bnn_pkg to every class score; otherwise the bias is zero.
module layer_three
   import bnn_pkg::*;
(
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [2:0]                       state,
   input  logic [FEAT_BITS-1:0]             features,
   input  logic [NUM_CLASSES*FEAT_BITS-1:0] weights,
   output logic [3:0]                       digit,
   output logic signed [8:0]                max_score,
   output logic                             done
);

   l3_state_t         fsm;
   logic [3:0]        cls;
   logic [1:0]        chunk;
   logic [7:0]        acc;

   logic              active;
   logic              last_chunk;
   logic              last_class;
   logic              take_best;
   logic [7:0]        feat_base;
   logic [10:0]       wt_base;
   logic [CHUNK_BITS-1:0] feat_chunk;
   logic [CHUNK_BITS-1:0] wt_chunk;
   logic [CHUNK_BITS-1:0] match;
   logic [5:0]        chunk_pop;
   logic signed [8:0] bias;
   logic signed [8:0] class_score;

`ifdef LAYER_THREE_BIAS_EN
   assign bias = bias_of(cls);
`else
   assign bias = '0;
`endif

   // Select the current feature plane and the matching slice of the class weights.
   always_comb begin
      active     = (state == s_LAYER_3);
      last_chunk = (chunk == 2'(NUM_CHUNKS - 1));
      last_class = (cls == 4'(NUM_CLASSES - 1));
      feat_base  = 8'(chunk) * 8'(CHUNK_BITS);
      wt_base    = 11'(cls) * 11'(FEAT_BITS) + 11'(feat_base);
      feat_chunk = features[feat_base +: CHUNK_BITS];
      wt_chunk   = weights[wt_base +: CHUNK_BITS];
      match      = ~(feat_chunk ^ wt_chunk);
   end

   popcount49 u_popcount (
      .bits  (match),
      .count (chunk_pop)
   );

   // Final score of the current class and whether it beats the running best.
   always_comb begin
      class_score = $signed({1'b0, acc}) + $signed({3'b000, chunk_pop}) + bias;
      take_best   = (cls == 4'd0) || (class_score > max_score);
   end

   // Sequencer, accumulator and best-class registers; frozen when inactive.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         fsm       <= RUN;
         cls       <= '0;
         chunk     <= '0;
         acc       <= '0;
         digit     <= '0;
         max_score <= '0;
         done      <= 1'b0;
      end else if (active) begin
         case (fsm)
            RUN: begin
               chunk <= chunk + 2'd1;
               if (last_chunk) begin
                  acc <= '0;
                  if (take_best) begin
                     digit     <= cls;
                     max_score <= class_score;
                  end
                  if (last_class) begin
                     fsm  <= FIN;
                     done <= 1'b1;
                  end else begin
                     cls <= cls + 4'd1;
                  end
               end else begin
                  acc <= acc + {2'b00, chunk_pop};
               end
            end
            FIN: begin
               // Result is held until the next reset.
            end
            default: fsm <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_layer_three.sv
// Self-checking bench for layer_three: directed corner cases plus random
// feature/weight sets with random inactive stalls, checked against a
// whole-vector scoring model.
module tb_layer_three;
   import bnn_pkg::*;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [2:0]          state = 3'b000;
   logic [195:0]        features = '0;
   logic [1959:0]       weights = '0;
   logic [3:0]          digit;
   logic signed [8:0]   max_score;
   logic                done;

   int n_checks = 0;
   int n_fail   = 0;

   layer_three dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .state     (state),
      .features  (features),
      .weights   (weights),
      .digit     (digit),
      .max_score (max_score),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int ref_bias(input int c);
`ifdef LAYER_THREE_BIAS_EN
      return int'(bias_of(4'(c)));
`else
      return 0 * c;
`endif
   endfunction

   // Score every class over the whole 196-bit vector; first maximum wins.
   task automatic model(output int exp_digit, output int exp_score);
      int s;
      exp_digit = 0;
      exp_score = 0;
      for (int c = 0; c < 10; c++) begin
         s = 0;
         for (int i = 0; i < 196; i++)
            if (features[i] == weights[c*196 + i]) s++;
         s += ref_bias(c);
         if (c == 0 || s > exp_score) begin
            exp_digit = c;
            exp_score = s;
         end
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      state = s_LAYER_3;
      tick(1);
      rst_n = 1'b1;
   endtask

   task automatic stall(input int n);
      logic [2:0] st;
      for (int k = 0; k < n; k++) begin
         st = 3'($urandom_range(0, 6));
         if (st >= 3'd4) st = st + 3'd1;
         state = st;
         tick(1);
      end
   endtask

   task automatic run_active(input int n, input bit stalls);
      for (int k = 0; k < n; k++) begin
         state = s_LAYER_3;
         tick(1);
         if (stalls && $urandom_range(0, 7) == 0) stall($urandom_range(1, 3));
      end
   endtask

   task automatic check_result(input string tag, input int ed, input int es);
      logic [8:0] es9;
      es9 = 9'(es);
      check({tag, "/done"}, 32'(done), 32'd1);
      check({tag, "/digit"}, 32'(digit), 32'(ed));
      check({tag, "/score"}, 32'($unsigned(max_score)), 32'(es9));
   endtask

   // Reset, run 40 active cycles, check done timing, result, and hold in FIN.
   task automatic full_run(input string tag, input bit stalls);
      int ed, es;
      model(ed, es);
      apply_reset();
      run_active(39, stalls);
      check({tag, "/done_early"}, 32'(done), 32'd0);
      run_active(1, 1'b0);
      check_result(tag, ed, es);
      state = s_LAYER_3;
      for (int i = 0; i < 196; i++) features[i] = 1'($urandom_range(0, 1));
      tick(3);
      check_result({tag, "/hold"}, ed, es);
   endtask

   task automatic randomize_vectors(input bit tie);
      int a, b;
      for (int i = 0; i < 196; i++) features[i] = 1'($urandom_range(0, 1));
      for (int i = 0; i < 1960; i++) weights[i] = 1'($urandom_range(0, 1));
      if (tie) begin
         a = $urandom_range(0, 8);
         b = $urandom_range(a + 1, 9);
         weights[b*196 +: 196] = weights[a*196 +: 196];
      end
   endtask

   initial begin
      int ed, es;

      // Reset state, with state held at s_LAYER_3 to show reset priority.
      rst_n = 1'b0;
      state = s_LAYER_3;
      features = '1;
      tick(2);
      check("reset/digit", 32'(digit), 32'd0);
      check("reset/score", 32'($unsigned(max_score)), 32'd0);
      check("reset/done", 32'(done), 32'd0);

      // Single winning class 3.
      features = '1;
      weights = '0;
      weights[3*196 +: 196] = '1;
      full_run("one_hot3", 1'b0);
`ifndef LAYER_THREE_BIAS_EN
      check("one_hot3/const_digit", 32'(digit), 32'd3);
      check("one_hot3/const_score", 32'($unsigned(max_score)), 32'd196);
`endif

      // Everything ties at 196; lowest class wins.
      features = '0;
      weights = '0;
      full_run("all_tie", 1'b0);
`ifndef LAYER_THREE_BIAS_EN
      check("all_tie/const_digit", 32'(digit), 32'd0);
      check("all_tie/const_score", 32'($unsigned(max_score)), 32'd196);
`endif

      // Classes 7 and 9 tie; 7 wins.
      features = '1;
      weights = '0;
      weights[7*196 +: 196] = '1;
      weights[9*196 +: 196] = '1;
      full_run("tie79", 1'b0);
`ifndef LAYER_THREE_BIAS_EN
      check("tie79/const_digit", 32'(digit), 32'd7);
`endif

      // Five-cycle stall after 17 active cycles: done after 45 edges.
      features = '1;
      weights = '0;
      weights[3*196 +: 196] = '1;
      model(ed, es);
      apply_reset();
      run_active(17, 1'b0);
      state = 3'b011;
      tick(5);
      check("stall/done_mid", 32'(done), 32'd0);
      run_active(22, 1'b0);
      check("stall/done_early", 32'(done), 32'd0);
      run_active(1, 1'b0);
      check_result("stall", ed, es);

      // Reset mid-run discards progress; a fresh 40-cycle run follows.
      randomize_vectors(1'b0);
      model(ed, es);
      apply_reset();
      run_active(20, 1'b0);
      apply_reset();
      check("midreset/done", 32'(done), 32'd0);
      check("midreset/digit", 32'(digit), 32'd0);
      check("midreset/score", 32'($unsigned(max_score)), 32'd0);
      run_active(39, 1'b0);
      check("midreset/done_early", 32'(done), 32'd0);
      run_active(1, 1'b0);
      check_result("midreset", ed, es);

`ifdef LAYER_THREE_BIAS_EN
      // Class 1 (191 matches + bias 5) ties class 2 (196 + bias 0).
      features = '1;
      weights = '0;
      weights[1*196 +: 196] = '1;
      weights[1*196 +: 5] = '0;
      weights[2*196 +: 196] = '1;
      full_run("bias", 1'b0);
      check("bias/const_digit", 32'(digit), 32'd1);
      check("bias/const_score", 32'($unsigned(max_score)), 32'd196);
`endif

      // Random vectors with random inactive stalls, some with forced ties.
      for (int t = 0; t < 8; t++) begin
         randomize_vectors(t[0]);
         full_run($sformatf("rand%0d", t), 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
